y86_mem_responder: RTL and testbench

Y86_MEM_RESPONDER -- requirements
Module: y86_mem_responder

---
 rtl/y86_mem_responder.sv | 138 +++++++++++++
 tb/tb_y86_mem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : y86_mem_responder
// Description : Byte-addressed data memory for a Y86-64 core. Accepts one
//               8-byte little-endian read or write at a time over a
//               valid/ready request channel, waits a fixed number of cycles,
//               then holds the response until the initiator takes it.
//               Out-of-range accesses report bad_mem through rsp_err and
//               never touch memory.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_mem_responder #(
    parameter int MEM_BYTES = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    // Width of a byte index into the storage array.
    localparam int c_ADDR_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    // Highest legal word base address; compared at full 64-bit width so
    // addresses close to 2^64-1 cannot wrap into range.
    localparam logic [63:0] c_LAST_ADDR = 64'(MEM_BYTES) - 64'd8;

    localparam logic [3:0] c_LATENCY = 4'(LATENCY);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_count;
    logic                r_write;
    logic [63:0]         r_addr;
    logic [63:0]         r_wdata;
    logic                r_rsp_valid;
    logic [63:0]         r_rsp_rdata;
    logic                r_rsp_err;

    // Storage is intentionally outside the reset domain: contents survive
    // reset and are never cleared.
    logic [7:0]          r_mem [0:MEM_BYTES-1];

    logic                w_accept;
    logic                w_do_access;
    logic                w_addr_err;
    logic [c_ADDR_W-1:0] w_base;
    logic [63:0]         w_rd_word;

    // Ready is gated by reset so nothing is offered while reset is held.
    assign req_ready   = (r_state == c_IDLE) && !reset;
    assign busy        = (r_state != c_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;

    assign w_accept    = req_valid && req_ready;
    assign w_do_access = (r_state == c_WAIT) && (r_count == 4'd0) && !reset;
    assign w_addr_err  = (r_addr > c_LAST_ADDR);
    assign w_base      = r_addr[c_ADDR_W-1:0];

    // Gather the eight bytes of the latched word, lowest address in the
    // least significant lane.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_rd_lane
            assign w_rd_word[8*g +: 8] = r_mem[w_base + c_ADDR_W'(g)];
        end
    endgenerate

    // Request/response control FSM with latched request and wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_count     <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= 64'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_count <= c_LATENCY;
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_addr_err;
                        r_rsp_rdata <= (w_addr_err || r_write) ? 64'd0 : w_rd_word;
                        r_state     <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write on the access edge; suppressed for out-of-range words.
    always_ff @(posedge clock) begin
        if (w_do_access && r_write && !w_addr_err) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[w_base + c_ADDR_W'(i)] <= r_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_mem_responder
// Description : Scoreboard bench for y86_mem_responder. Instance A uses
//               LATENCY=2 for directed read/write, boundary, backpressure,
//               isolation and reset cases; instance B uses LATENCY=0 with a
//               continuously valid request stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_mem_responder;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    localparam logic [63:0] c_D1 = 64'h1122334455667788;
    localparam logic [63:0] c_D2 = 64'hA5A5_0F0F_C3C3_9696;
    localparam logic [63:0] c_D3 = 64'hFFFF_EEEE_DDDD_CCCC;
    localparam logic [63:0] c_D4 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] c_D5 = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam logic [63:0] c_DB = 64'hCAFE_F00D_1234_5678;

    logic        clock;
    logic        reset;

    logic        req_valid_a, req_ready_a, req_write_a;
    logic [63:0] req_addr_a, req_wdata_a;
    logic        rsp_valid_a, rsp_ready_a, rsp_err_a, busy_a;
    logic [63:0] rsp_rdata_a;

    logic        req_valid_b, req_ready_b, req_write_b;
    logic [63:0] req_addr_b, req_wdata_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_err_b, busy_b;
    logic [63:0] rsp_rdata_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic a_pend = 1'b0, a_prev = 1'b0;
    int   a_acc  = 0;
    logic b_pend = 1'b0, b_prev = 1'b0;
    int   b_acc  = 0;
    int   b_last = -1;
    int   b_accepts = 0;

    y86_mem_responder #(.MEM_BYTES(256), .LATENCY(2)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid_a),
        .req_ready (req_ready_a),
        .req_write (req_write_a),
        .req_addr  (req_addr_a),
        .req_wdata (req_wdata_a),
        .rsp_valid (rsp_valid_a),
        .rsp_ready (rsp_ready_a),
        .rsp_rdata (rsp_rdata_a),
        .rsp_err   (rsp_err_a),
        .busy      (busy_a)
    );

    y86_mem_responder #(.MEM_BYTES(256), .LATENCY(0)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_write (req_write_b),
        .req_addr  (req_addr_b),
        .req_wdata (req_wdata_b),
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready_b),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b),
        .busy      (busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor A: response latency and scoreboard pop on each handshake.
    always @(negedge clock) begin
        if (reset) begin
            a_pend = 1'b0;
            a_prev = 1'b0;
        end else begin
            if (rsp_valid_a && !a_prev) begin
                check("a_latency", a_pend ? 64'(cyc - a_acc) : 64'hFFFF, 64'd3);
                a_pend = 1'b0;
            end
            if (req_valid_a && req_ready_a) begin
                a_pend = 1'b1;
                a_acc  = cyc + 1;
            end
            if (rsp_valid_a && rsp_ready_a) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_rsp actual=rsp required=none");
                end else begin
                    ea = q_a.pop_front();
                    check("a_rdata", rsp_rdata_a, ea.rdata);
                    check("a_err", {63'd0, rsp_err_a}, {63'd0, ea.err});
                end
            end
            a_prev = rsp_valid_a;
        end
    end

    // Monitor B: pushes expectations at accept, checks accept spacing,
    // latency and pops on each handshake.
    always @(negedge clock) begin
        if (reset) begin
            b_pend = 1'b0;
            b_prev = 1'b0;
            b_last = -1;
        end else begin
            if (rsp_valid_b && !b_prev) begin
                check("b_latency", b_pend ? 64'(cyc - b_acc) : 64'hFFFF, 64'd1);
                b_pend = 1'b0;
            end
            if (req_valid_b && req_ready_b) begin
                if (b_last >= 0)
                    check("b_accept_interval", 64'(cyc + 1 - b_last), 64'd3);
                b_last = cyc + 1;
                b_accepts++;
                b_pend = 1'b1;
                b_acc  = cyc + 1;
                eb.rdata = req_write_b ? 64'd0 : c_DB;
                eb.err   = 1'b0;
                q_b.push_back(eb);
            end else if (!req_valid_b) begin
                b_last = -1;
            end
            if (rsp_valid_b && rsp_ready_b) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_rsp actual=rsp required=none");
                end else begin
                    eb = q_b.pop_front();
                    check("b_rdata", rsp_rdata_b, eb.rdata);
                    check("b_err", {63'd0, rsp_err_b}, {63'd0, eb.err});
                end
            end
            b_prev = rsp_valid_b;
        end
    end

    // Present a request on A until accepted, then scramble the inputs so any
    // later use of them by the DUT shows up in the response.
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] wd);
        logic ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        req_valid_a = 1'b1;
        req_write_a = w;
        req_addr_a  = a;
        req_wdata_a = wd;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (req_ready_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("a_accept_timeout", {63'd0, ok}, 64'd1);
        @(posedge clock);
        #1;
        req_valid_a = 1'b0;
        req_write_a = ~w;
        req_addr_a  = 64'hDEAD_BEEF_0BAD_F00D;
        req_wdata_a = ~wd;
    endtask

    task automatic wait_idle_a();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (!busy_a && !rsp_valid_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("a_idle_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] er, input logic ee);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        q_a.push_back(e);
        issue(w, a, wd);
        wait_idle_a();
    endtask

    initial begin
        logic [63:0] hold_d;
        logic        hold_e;
        logic        ok;
        exp_t        e;

        reset       = 1'b1;
        req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = 64'd0; req_wdata_a = 64'd0;
        rsp_ready_a = 1'b1;
        req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 64'd0; req_wdata_b = 64'd0;
        rsp_ready_b = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_req_ready", {63'd0, req_ready_a}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid_a}, 64'd0);
        check("rst_busy", {63'd0, busy_a}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata_a, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err_a}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("post_rst_req_ready", {63'd0, req_ready_a}, 64'd1);

        // Write then read back, plus one byte seen directly in storage
        do_req(1'b1, 64'h10, c_D1, 64'd0, 1'b0);
        do_req(1'b0, 64'h10, 64'd0, c_D1, 1'b0);
        check("mem_0x10", {56'd0, dut_a.r_mem[16]}, 64'h88);

        // Boundary: last legal word, first illegal, wrap-around address
        do_req(1'b1, 64'd248, c_D2, 64'd0, 1'b0);
        do_req(1'b0, 64'd248, 64'd0, c_D2, 1'b0);
        do_req(1'b0, 64'd249, 64'd0, 64'd0, 1'b1);
        do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, c_D3, 64'd0, 1'b1);
        do_req(1'b0, 64'd248, 64'd0, c_D2, 1'b0);
        do_req(1'b1, 64'h20, c_D4, 64'd0, 1'b0);
        do_req(1'b0, 64'h20, 64'd0, c_D4, 1'b0);

        // Backpressure: response held for five cycles
        e.rdata = c_D1;
        e.err   = 1'b0;
        q_a.push_back(e);
        rsp_ready_a = 1'b0;
        issue(1'b0, 64'h10, 64'd0);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (rsp_valid_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("bp_rsp_timeout", {63'd0, ok}, 64'd1);
        hold_d = rsp_rdata_a;
        hold_e = rsp_err_a;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check("bp_valid", {63'd0, rsp_valid_a}, 64'd1);
            check("bp_rdata", rsp_rdata_a, hold_d);
            check("bp_err", {63'd0, rsp_err_a}, {63'd0, hold_e});
            check("bp_req_ready", {63'd0, req_ready_a}, 64'd0);
        end
        @(posedge clock);
        #1 rsp_ready_a = 1'b1;
        @(posedge clock);
        #1;
        check("bp_busy_after", {63'd0, busy_a}, 64'd0);
        check("bp_valid_after", {63'd0, rsp_valid_a}, 64'd0);
        check("bp_req_ready_after", {63'd0, req_ready_a}, 64'd1);

        // Reset while a write is waiting: write must be abandoned
        issue(1'b1, 64'h20, c_D5);
        #2 reset = 1'b1;
        #1;
        check("rw_busy", {63'd0, busy_a}, 64'd0);
        check("rw_rsp_valid", {63'd0, rsp_valid_a}, 64'd0);
        check("rw_req_ready", {63'd0, req_ready_a}, 64'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        @(negedge clock);
        check("rw_req_ready_after", {63'd0, req_ready_a}, 64'd1);
        do_req(1'b0, 64'h20, 64'd0, c_D4, 1'b0);

        // LATENCY=0 stream: write, then continuous reads of the same word
        @(posedge clock);
        #1;
        req_valid_b = 1'b1;
        req_write_b = 1'b1;
        req_addr_b  = 64'd0;
        req_wdata_b = c_DB;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (req_ready_b) begin
                ok = 1'b1;
                break;
            end
        end
        check("b_accept_timeout", {63'd0, ok}, 64'd1);
        @(posedge clock);
        #1 req_write_b = 1'b0;
        repeat (20) @(posedge clock);
        #1 req_valid_b = 1'b0;
        repeat (6) @(negedge clock);
        check("b_accept_count", {63'd0, (b_accepts >= 6)}, 64'd1);
        check("b_busy_end", {63'd0, busy_b}, 64'd0);

        check("a_queue_empty", 64'(q_a.size()), 64'd0);
        check("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
